// File: rtl/uart_rx_ctrl_if.sv
// Handshake bundle between the UART receive controller and its datapath blocks:
// enables and edge index out, registered checker flags in, per-frame result pulses out.
interface uart_rx_ctrl_if #(
  parameter int PRESC_W = 6
);
  logic               Dat_samp_en;
  logic               Str_chk_en;
  logic               Deser_en;
  logic               Par_chk_en;
  logic               Stp_chk_en;
  logic [PRESC_W-1:0] Edge_cnt;
  logic               Str_err;
  logic               Par_err;
  logic               Stp_err;
  logic               Data_valid;
  logic               Par_error;
  logic               Stop_error;

  modport master (
    output Dat_samp_en, Str_chk_en, Deser_en, Par_chk_en, Stp_chk_en, Edge_cnt,
    output Data_valid, Par_error, Stop_error,
    input  Str_err, Par_err, Stp_err
  );

  modport slave (
    input  Dat_samp_en, Str_chk_en, Deser_en, Par_chk_en, Stp_chk_en, Edge_cnt,
    input  Data_valid, Par_error, Stop_error,
    output Str_err, Par_err, Stp_err
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: walks start/data/parity/stop using an oversampling edge
// counter, drives the datapath enables and emits one result pulse per completed frame.
module uart_rx_ctrl #(
  parameter int DATA_W  = 8,
  parameter int PRESC_W = 6
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               RX_IN,
  input  logic [PRESC_W-1:0] Prescale,
  input  logic               PAR_EN,
  uart_rx_ctrl_if.master     dp
);
  localparam int BC_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]         state_reg, state_next;
  logic [PRESC_W-1:0] ec_reg, ec_next;
  logic [BC_W-1:0]    bc_reg, bc_next;
  logic [PRESC_W-1:0] p_reg, p_next;
  logic               pe_reg, pe_next;
  logic               perr_reg, perr_next;
  logic               dv_reg, dv_next;
  logic               par_error_reg, par_error_next;
  logic               stop_error_reg, stop_error_next;

  logic [PRESC_W-1:0] p_sel;
  logic [PRESC_W-1:0] chk;
  logic [PRESC_W-1:0] p_last;
  logic               bit_end;
  logic               in_chk_win;

  // Anything other than 8/16/32 falls back to 8 so checker timing stays valid.
  assign p_sel = (Prescale == PRESC_W'(8) || Prescale == PRESC_W'(16) ||
                  Prescale == PRESC_W'(32)) ? Prescale : PRESC_W'(8);

  assign chk        = (p_reg >> 1) + PRESC_W'(2);
  assign p_last     = p_reg - PRESC_W'(1);
  assign bit_end    = (ec_reg == p_last);
  assign in_chk_win = (ec_reg >= chk);

  always_comb begin
    state_next      = state_reg;
    ec_next         = bit_end ? '0 : ec_reg + 1'b1;
    bc_next         = bc_reg;
    p_next          = p_reg;
    pe_next         = pe_reg;
    perr_next       = perr_reg;
    dv_next         = 1'b0;
    par_error_next  = 1'b0;
    stop_error_next = 1'b0;
    case (state_reg)
      IDLE: begin
        ec_next = '0;
        if (!RX_IN) begin
          // The detect cycle itself is edge 0 of the start bit.
          state_next = START;
          ec_next    = PRESC_W'(1);
          p_next     = p_sel;
          pe_next    = PAR_EN;
          perr_next  = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          bc_next    = '0;
          state_next = dp.Str_err ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          bc_next = bc_reg + 1'b1;
          if (bc_reg == BC_W'(DATA_W - 1)) begin
            bc_next    = '0;
            state_next = pe_reg ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          perr_next  = dp.Par_err;
          state_next = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_next = IDLE;
          if (perr_reg)        par_error_next  = 1'b1;
          else if (dp.Stp_err) stop_error_next = 1'b1;
          else                 dv_next         = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        ec_next    = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg      <= IDLE;
      ec_reg         <= '0;
      bc_reg         <= '0;
      p_reg          <= '0;
      pe_reg         <= 1'b0;
      perr_reg       <= 1'b0;
      dv_reg         <= 1'b0;
      par_error_reg  <= 1'b0;
      stop_error_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      ec_reg         <= ec_next;
      bc_reg         <= bc_next;
      p_reg          <= p_next;
      pe_reg         <= pe_next;
      perr_reg       <= perr_next;
      dv_reg         <= dv_next;
      par_error_reg  <= par_error_next;
      stop_error_reg <= stop_error_next;
    end
  end

  assign dp.Dat_samp_en = (state_reg != IDLE);
  assign dp.Str_chk_en  = (state_reg == START)  && in_chk_win;
  assign dp.Deser_en    = (state_reg == DATA)   && (ec_reg == chk);
  assign dp.Par_chk_en  = (state_reg == PARITY) && in_chk_win;
  assign dp.Stp_chk_en  = (state_reg == STOP)   && in_chk_win;
  assign dp.Edge_cnt    = ec_reg;
  assign dp.Data_valid  = dv_reg;
  assign dp.Par_error   = par_error_reg;
  assign dp.Stop_error  = stop_error_reg;
endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Sequencing controller for the UART receiver datapath.
- Owns the oversampling edge counter and the bit counter, and walks the frame: start, data, optional parity, stop.
- Drives the enables of the data sampler, start checker, deserializer, parity checker and stop checker.
- Consumes their error flags and issues a one-cycle data-valid pulse per good frame, plus error pulses for dropped frames.

Parameters:
- DATA_W, 8, data bits per frame (LSB first).
- PRESC_W, 6, width of the Prescale input.

Ports:
- CLK  in  1  receiver clock (oversampling clock).
- RST  in  1  synchronous reset, active-high.
- RX_IN  in  1  serial line, idle high.
- Prescale  in  PRESC_W  oversampling ratio; legal values are 8, 16 and 32.
- PAR_EN  in  1  a parity bit follows the data bits.
- Str_err  in  1  start-bit error, registered one cycle after Str_chk_en.
- Par_err  in  1  parity error, registered one cycle after Par_chk_en.
- Stp_err  in  1  stop-bit error, registered one cycle after Stp_chk_en.
- Dat_samp_en  out  1  sampler enable.
- Str_chk_en  out  1  start-check enable.
- Deser_en  out  1  deserializer shift strobe.
- Par_chk_en  out  1  parity-check enable.
- Stp_chk_en  out  1  stop-check enable.
- Edge_cnt  out  PRESC_W  current edge index within the bit; used by the sampler.
- Data_valid  out  1  good-frame pulse.
- Par_error  out  1  parity-drop pulse.
- Stop_error  out  1  framing-drop pulse.

Behaviour:
- Reset: every output is 0, the FSM is in IDLE, and both counters are 0. A reset asserted mid-frame aborts the frame; no pulses are emitted.
- Frame configuration: P = Prescale and PE = PAR_EN are latched on the IDLE->START transition and held for the whole frame. A latched P outside {8, 16, 32} is treated as 8.
- Derived values: H = P/2. CHK = H+2.
- Edge counter: counts 0..P-1 and wraps to 0. The wrap marks the end of a bit. Bit counter bc counts the data bits 0..DATA_W-1.
- IDLE: Edge_cnt = 0. When RX_IN == 0 (sampled), go to START with Edge_cnt = 1, because the detect cycle counts as edge 0.
- Dat_samp_en is 1 in every state except IDLE.
- START:
  - Str_chk_en = 1 while Edge_cnt is in [CHK, P-1].
  - At Edge_cnt == P-1: if Str_err == 1, go to IDLE (glitch, silent drop, no pulse); otherwise go to DATA with bc = 0.
- DATA:
  - Deser_en pulses one cycle at Edge_cnt == CHK.
  - At Edge_cnt == P-1: bc increments. When bc == DATA_W-1, go to PARITY if PE is set, otherwise to STOP.
- PARITY:
  - Par_chk_en = 1 while Edge_cnt is in [CHK, P-1].
  - At Edge_cnt == P-1, latch perr = Par_err and go to STOP.
- STOP:
  - Stp_chk_en = 1 while Edge_cnt is in [CHK, P-1].
  - At Edge_cnt == P-1, go to IDLE. On the next cycle exactly one of these pulses for one cycle:
    - Par_error = 1 if perr is set;
    - else Stop_error = 1 if Stp_err is set;
    - else Data_valid = 1.
  - perr is cleared on entry to START.
- Checker timing: the errors are registered one cycle after enable, so each error input is sampled at Edge_cnt == P-1, which is at least CHK+1. P = 8 is the minimum that satisfies this.
- Back-to-back frames: a start bit that begins on the cycle after STOP ends is detected in IDLE. The result pulse and the new frame's START entry may coincide.
- RX_IN activity in non-IDLE states does not affect the state sequence; the checkers judge the bit values.
- Prescale and PAR_EN changes mid-frame are ignored until the next IDLE->START.
- Frame latency, start detect to result pulse: P × (2 + DATA_W + PE) cycles. For P = 8, no parity: 80 cycles.

Test Plan:
- Good frame, P = 8, PAR_EN = 0, data 0xA5, all errors held 0:
  - Deser_en pulses exactly 8 times, at Edge_cnt == 6.
  - Data_valid pulses once, 80 cycles after the RX_IN fall.
  - Par_error and Stop_error stay 0.
- Glitch: RX_IN low for 2 cycles, bench drives Str_err = 1 from Edge_cnt 7 of START:
  - Returns to IDLE after 8 cycles.
  - No Deser_en, no pulses.
- Parity error: P = 16, PAR_EN = 1, Par_err = 1 during PARITY:
  - Par_chk_en is high for Edge_cnt 10..15.
  - Par_error pulses once at cycle 176; Data_valid stays 0.
- Framing error: P = 32, PAR_EN = 0, Stp_err = 1 in STOP:
  - Stop_error pulses once at cycle 320; Data_valid stays 0.
- Back-to-back: two frames 0x3C and 0xC3, P = 8, second start bit immediately after the first stop:
  - Two Data_valid pulses, 80 cycles apart.
- Reset mid-DATA (bc = 3) by asserting RST for 1 cycle:
  - All outputs go to 0 on the next cycle and the FSM is in IDLE.
  - No Data_valid; the following frame is received normally.
- Illegal Prescale = 12:
  - The frame completes with P = 8 timing (Data_valid at cycle 80).
